// File: rtl/rca_pkg.sv
// Shared constants, state encoding and width helper for the nibble-serial
// ripple-carry word sequencer.
package rca_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } rca_state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rca_seq_ctrl.sv
// Control FSM for the word sequencer: handshake generation, nibble counter
// and the one-pass-per-nibble ADD phase.
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int NUM_NIB = 4,
    parameter int CNT_W   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic accept,
    output logic add_en,
    output logic last,
    output logic out_valid
);

    rca_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ov_q, ov_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ov_d     = ov_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        add_en   = 1'b0;
        last     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                add_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_NIB - 1)) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // out_valid rises one cycle after entry; leave only on a completed handshake
                if (!ov_q) begin
                    ov_d = 1'b1;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = ov_q;

endmodule

// File: rtl/rca_word_sequencer.sv
// Word-wide adder built from an external 4-bit ripple-carry adder, one nibble
// per cycle LSB first. Optional overflow flag: define RCA_SEQ_OVF_FLAG_EN.
module rca_word_sequencer
    import rca_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    input  logic              op_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_cout,
    output logic [NIB_W-1:0]  add_a,
    output logic [NIB_W-1:0]  add_b,
    output logic              add_cin,
    input  logic [NIB_W-1:0]  add_sum,
    input  logic              add_cout
`ifdef RCA_SEQ_OVF_FLAG_EN
   ,output logic              out_ovf
`endif
);

    localparam int NUM_NIB = WORD_W / NIB_W;
    localparam int CNT_W   = (clog2(NUM_NIB) < 1) ? 1 : clog2(NUM_NIB);

    logic              accept, add_en, last;
    logic [WORD_W-1:0] a_sh, b_sh, res, res_nxt;
    logic              carry;

    rca_seq_ctrl #(
        .NUM_NIB (NUM_NIB),
        .CNT_W   (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .accept    (accept),
        .add_en    (add_en),
        .last      (last),
        .out_valid (out_valid)
    );

    // Adder inputs come straight from registers; no input-to-adder comb path
    assign add_a   = a_sh[NIB_W-1:0];
    assign add_b   = b_sh[NIB_W-1:0];
    assign add_cin = carry;

    // Sum nibbles enter at the top and walk down, so after NUM_NIB passes the word is aligned
    assign res_nxt = (res >> NIB_W) | (WORD_W'(add_sum) << (WORD_W - NIB_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            if (accept) begin
                a_sh  <= op_a;
                b_sh  <= op_b;
                carry <= op_cin;
            end else if (add_en) begin
                a_sh  <= a_sh >> NIB_W;
                b_sh  <= b_sh >> NIB_W;
                carry <= add_cout;
                res   <= res_nxt;
            end
            if (last) begin
                out_sum  <= res_nxt;
                out_cout <= add_cout;
            end
        end
    end

`ifdef RCA_SEQ_OVF_FLAG_EN
    logic a_msb, b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= op_a[WORD_W-1];
                b_msb <= op_b[WORD_W-1];
            end
            if (last) begin
                out_ovf <= (a_msb == b_msb) && (res_nxt[WORD_W-1] != a_msb);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Directed bench for rca_word_sequencer with a behavioural 4-bit adder on the
// add_* ports and a result scoreboard.
module tb_rca_word_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a, op_b;
    logic        op_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;
`ifdef RCA_SEQ_OVF_FLAG_EN
    logic        out_ovf;
`endif

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [15:0] sum;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // The team's combinational 4-bit ripple-carry adder, modelled behaviourally
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    rca_word_sequencer #(.WORD_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
`ifdef RCA_SEQ_OVF_FLAG_EN
       ,.out_ovf   (out_ovf)
`endif
    );

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
        exp_t        r;
        logic [16:0] s;
        s      = {1'b0, a} + {1'b0, b} + {16'b0, c};
        r.sum  = s[15:0];
        r.cout = s[16];
        r.ovf  = (a[15] == b[15]) && (s[15] != a[15]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c, input bit push);
        int k;
        k        = 0;
        op_a     = a;
        op_b     = b;
        op_cin   = c;
        in_valid = 1'b1;
        while (!in_ready && k < 40) begin
            tick();
            k++;
        end
        chk("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        if (push) sb.push_back(model(a, b, c));
    endtask

    task automatic wait_lat(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk(tag, n, 5);
    endtask

    // Scoreboard: pop and compare on every completed output handshake
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sum", out_sum, e.sum);
                chk("cout", out_cout, e.cout);
`ifdef RCA_SEQ_OVF_FLAG_EN
                chk("ovf", out_ovf, e.ovf);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b1;
        op_a      = 16'hFFFF;
        op_b      = 16'h0001;
        op_cin    = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // reset state, with in_valid asserted throughout reset
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_cin", add_cin, 0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        repeat (8) tick();
        chk("no_capture_in_rst", out_valid, 0);

        // basic sum and full-carry ripple cases
        issue(16'h1234, 16'h4321, 1'b0, 1'b1);
        wait_lat("lat_basic");
        tick();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        wait_lat("lat_ripple1");
        tick();
        issue(16'h0FFF, 16'h0000, 1'b1, 1'b1);
        wait_lat("lat_ripple2");
        tick();

        // reset two cycles into ADD: partial result discarded
        issue(16'hABCD, 16'h1111, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_sum", out_sum, 0);
        chk("midrst_add_a", add_a, 0);
        chk("midrst_add_b", add_b, 0);
        chk("midrst_add_cin", add_cin, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        repeat (8) tick();
        chk("midrst_no_result", out_valid, 0);
        issue(16'h00FF, 16'h0F01, 1'b0, 1'b1);
        wait_lat("lat_after_rst");
        tick();

        // backpressure: result held, in_valid pulses ignored
        out_ready = 1'b0;
        issue(16'hA5A5, 16'h5A5A, 1'b0, 1'b1);
        wait_lat("lat_bp");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            op_a     = 16'h1111;
            op_b     = 16'h2222;
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", out_sum, 16'hFFFF);
            chk("bp_cout", out_cout, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_released", out_valid, 0);
        issue(16'h0005, 16'h0008, 1'b0, 1'b1);
        wait_lat("lat_after_bp");
        tick();

        // signed overflow cases
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        wait_lat("lat_ovf1");
        tick();
        issue(16'h8000, 16'hFFFF, 1'b0, 1'b1);
        wait_lat("lat_ovf2");
        tick();

        // back-to-back with in_valid held high
        op_a     = 16'h1357;
        op_b     = 16'h2468;
        op_cin   = 1'b0;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_first_ready", in_ready, 1);
        tick();
        sb.push_back(model(16'h1357, 16'h2468, 1'b0));
        op_a   = 16'hFFFF;
        op_b   = 16'hFFFF;
        op_cin = 1'b1;
        n      = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_gap", n + 1, 7);
        tick();
        in_valid = 1'b0;
        sb.push_back(model(16'hFFFF, 16'hFFFF, 1'b1));
        wait_lat("lat_b2b");
        tick();

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
